param_sync_fifo: RTL
====================

PARAM_SYNC_FIFO -- requirements
Module: param_sync_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, word width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 4, where DEPTH = 2**ADDR_WIDTH entries.
REQ-003 SHALL have parameter AFULL_THRESH, default DEPTH-2, the almost-full level; legal range 1..DEPTH.
REQ-004 SHALL have parameter AEMPTY_THRESH, default 2, the almost-empty level; legal range 0..DEPTH-1.
REQ-005 SHALL have parameter FWFT, default 0: 0 = registered-read mode, 1 = first-word-fall-through mode.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-007 SHALL have port rest, input, 1 bit: reset, synchronous and active-high.
REQ-008 SHALL have port w_inc, input, 1 bit: write request.
REQ-009 SHALL have port w_data, input, DATA_WIDTH bits: write data.
REQ-010 SHALL have port w_full, output, 1 bit: FIFO full.
REQ-011 SHALL have port w_afull, output, 1 bit: almost full.
REQ-012 SHALL have port r_inc, input, 1 bit: read request.
REQ-013 SHALL have port r_data, output, DATA_WIDTH bits: read data.
REQ-014 SHALL have port r_empty, output, 1 bit: FIFO empty.
REQ-015 SHALL have port r_aempty, output, 1 bit: almost empty.
REQ-016 SHALL have port count, output, ADDR_WIDTH+1 bits: current occupancy, 0..DEPTH.
REQ-017 SHALL have port err_clr, input, 1 bit: clears the sticky error flags.
REQ-018 SHALL have port overflow, output, 1 bit: sticky write-while-full error.
REQ-019 SHALL have port underflow, output, 1 bit: sticky read-while-empty error.

Function
REQ-020 SHALL hold write and read pointers that are ADDR_WIDTH bits wide, wrap modulo DEPTH, and address a DEPTH x DATA_WIDTH memory.
REQ-021 SHALL accept a write when w_inc=1 and w_full=0: mem[wptr] <= w_data and wptr advances by 1.
REQ-022 SHALL accept a read when r_inc=1 and r_empty=0: rptr advances by 1.
REQ-023 SHALL evaluate acceptance against the flag values present at the start of the cycle.
REQ-024 SHALL, when full with w_inc=r_inc=1, accept the read, reject the write and set overflow.
REQ-025 SHALL, when empty with w_inc=r_inc=1, accept the write, reject the read and set underflow.
REQ-026 SHALL update count as follows: +1 on a write only, -1 on a read only, unchanged on both or on neither; count SHALL never leave the range 0..DEPTH.
REQ-027 SHALL drive the flags combinationally from the registered count: w_full=(count==DEPTH), r_empty=(count==0), w_afull=(count>=AFULL_THRESH), r_aempty=(count<=AEMPTY_THRESH).
REQ-028 SHALL, when FWFT=0, load r_data <= mem[rptr] on the edge of an accepted read; the data is valid in the following cycle and r_data holds its value otherwise (one-cycle read latency).
REQ-029 SHALL, when FWFT=1, drive r_data combinationally as mem[rptr] whenever r_empty=0, with r_inc acting as a pop; r_data is don't-care while empty.
REQ-030 SHALL make a word written into an empty FIFO visible as r_empty=0 in the cycle after the write edge, in both modes.
REQ-031 SHALL set overflow on any cycle with w_inc=1 and w_full=1.
REQ-032 SHALL set underflow on any cycle with r_inc=1 and r_empty=1.
REQ-033 SHALL clear overflow and underflow on err_clr=1; a same-cycle set event SHALL win over the clear.
REQ-034 SHALL leave memory contents, pointers and count unchanged on any rejected operation.

Reset
REQ-035 SHALL, on a clk edge with rest=1, force wptr=0, rptr=0, count=0, r_data=0, overflow=0 and underflow=0, giving r_empty=1, r_aempty=1, w_full=0 and w_afull=0.
REQ-036 SHALL give rest priority over all concurrent w_inc, r_inc and err_clr activity.
REQ-037 SHALL, on reset mid-operation, discard all stored words; memory SHALL NOT be reset.

Verification
REQ-038 Defaults, FWFT=0: write 0x01..0x10 (16 words) -> w_full=1 and count=16 after the 16th edge; w_afull=1 from count=14; then 16 reads -> r_data=0x01..0x10 in order, each one cycle after its read, and r_empty=1 at the end.
REQ-039 Full: with the FIFO full, assert w_inc alone -> overflow=1, count stays 16; then w_inc=r_inc=1 for one cycle -> count=15, the write is dropped; then pulse err_clr -> overflow=0.
REQ-040 Empty: with the FIFO empty, r_inc=1 -> underflow=1 and r_data unchanged; then w_inc=r_inc=1 with w_data=0xAA -> count=1 and the next read returns 0xAA.
REQ-041 Wrap-around: 40 cycles of simultaneous streaming of an incrementing pattern at count=3 -> count constant at 3, output ordering preserved across the pointer wraps, r_aempty=0.
REQ-042 FWFT=1: write 0x5A into an empty FIFO -> next cycle r_empty=0 and r_data=0x5A with no r_inc; then r_inc=1 -> r_empty=1 on the following cycle.
REQ-043 Reset mid-operation: with count=9 and w_inc=1, assert rest for one edge -> count=0, r_empty=1, all flags deasserted, and the subsequent read data comes only from post-reset writes.

Source files
------------

// File: rtl/param_sync_fifo.sv
// Single-clock FIFO with a parameterised depth, almost-full/almost-empty levels,
// sticky overflow/underflow flags and a choice of registered or first-word-fall-through reads.
module param_sync_fifo #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDR_WIDTH    = 4,
  parameter int AFULL_THRESH  = (2 ** ADDR_WIDTH) - 2,
  parameter int AEMPTY_THRESH = 2,
  parameter bit FWFT          = 1'b0
) (
  input  logic                  clk,
  input  logic                  rest,
  input  logic                  w_inc,
  input  logic [DATA_WIDTH-1:0] w_data,
  output logic                  w_full,
  output logic                  w_afull,
  input  logic                  r_inc,
  output logic [DATA_WIDTH-1:0] r_data,
  output logic                  r_empty,
  output logic                  r_aempty,
  output logic [ADDR_WIDTH:0]   count,
  input  logic                  err_clr,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int CW    = ADDR_WIDTH + 1;

  localparam logic [ADDR_WIDTH:0] DepthCnt  = CW'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AFullCnt  = CW'(AFULL_THRESH);
  localparam logic [ADDR_WIDTH:0] AEmptyCnt = CW'(AEMPTY_THRESH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH-1:0] wrPtr_q, wrPtr_d;
  logic [ADDR_WIDTH-1:0] rdPtr_q, rdPtr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [DATA_WIDTH-1:0] rdData_q, rdData_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;

  logic wrAccept;
  logic rdAccept;

  // Acceptance uses the flags as they stand at the start of the cycle, so a
  // full FIFO can still drain and an empty one can still fill in the same cycle.
  assign w_full   = (count_q == DepthCnt);
  assign r_empty  = (count_q == '0);
  assign w_afull  = (count_q >= AFullCnt);
  assign r_aempty = (count_q <= AEmptyCnt);
  assign count    = count_q;

  assign wrAccept = w_inc & ~w_full;
  assign rdAccept = r_inc & ~r_empty;

  assign overflow  = overflow_q;
  assign underflow = underflow_q;

  always_comb begin
    wrPtr_d     = wrPtr_q;
    rdPtr_d     = rdPtr_q;
    count_d     = count_q;
    rdData_d    = rdData_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    if (wrAccept) begin
      wrPtr_d = wrPtr_q + ADDR_WIDTH'(1);
    end
    if (rdAccept) begin
      rdPtr_d  = rdPtr_q + ADDR_WIDTH'(1);
      rdData_d = mem[rdPtr_q];
    end

    unique case ({wrAccept, rdAccept})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // A clear and a fresh error in the same cycle leave the flag set.
    if (err_clr) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
    if (w_inc && w_full) begin
      overflow_d = 1'b1;
    end
    if (r_inc && r_empty) begin
      underflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rest) begin
      wrPtr_q     <= '0;
      rdPtr_q     <= '0;
      count_q     <= '0;
      rdData_q    <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wrPtr_q     <= wrPtr_d;
      rdPtr_q     <= rdPtr_d;
      count_q     <= count_d;
      rdData_q    <= rdData_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is never cleared; reset only makes the old words unreachable.
  always_ff @(posedge clk) begin
    if (!rest && wrAccept) begin
      mem[wrPtr_q] <= w_data;
    end
  end

  if (FWFT) begin : g_fwft
    assign r_data = mem[rdPtr_q];
  end else begin : g_registered
    assign r_data = rdData_q;
  end

endmodule
